// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next fetch address selection and alignment/range fault detection
module pc_gen
    import fetch_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] next_pc,
    output logic        pc_fault,
    output logic        target_fault
);

    // Widened by one bit so a full 4 GiB memory depth does not overflow the limit
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

    always_comb begin
        next_pc = pc;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (advance) begin
            next_pc = pc + PC_STEP;
        end
    end

    assign pc_fault     = (pc[1:0] != 2'b00) || ({1'b0, pc} >= LIMIT);
    assign target_fault = (redirect_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-entry instruction fetch stage with redirect and sticky fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic               fault
);

    fetch_state_t state, state_n;
    logic [31:0]  next_pc;
    logic         pc_fault, target_fault, advance;
    logic         pc_we, capture, flush;

    assign advance = (!out_valid || out_ready) && !redirect_valid;

    pc_gen #(
        .MEM_WORDS(MEM_WORDS)
    ) u_pc_gen (
        .pc             (pc),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .next_pc        (next_pc),
        .pc_fault       (pc_fault),
        .target_fault   (target_fault)
    );

    // A bad current pc wins over everything; a redirect then wins over advance/stall
    always_comb begin
        state_n = state;
        pc_we   = 1'b0;
        capture = 1'b0;
        flush   = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (pc_fault) begin
                    state_n = FAULT;
                    flush   = 1'b1;
                end else if (redirect_valid) begin
                    flush = 1'b1;
                    if (target_fault) begin
                        state_n = FAULT;
                    end else begin
                        pc_we = 1'b1;
                    end
                end else if (advance) begin
                    capture = 1'b1;
                    pc_we   = 1'b1;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= NOP;
            out_pc    <= 32'h0000_0000;
        end else begin
            if (pc_we) begin
                pc <= next_pc;
            end
            if (capture) begin
                out_instr <= instr;
                out_pc    <= pc;
                out_valid <= 1'b1;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign fault = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a behavioural instruction memory
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] instr_mem [0:63];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Stands in for instrMem: combinational read, zero outside the populated range
    assign instr = (pc < 32'h100) ? instr_mem[pc[7:2]] : 32'h0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: pc=%h v=%b instr=%h opc=%h fault=%b required all zero", pc, out_valid, out_instr, out_pc, fault);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 32'h0 || out_valid !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: pc=%h v=%b fault=%b required 0/0/0", pc, out_valid, fault);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        out_ready = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_idle_exit: pc=%h v=%b required 0 0", pc, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pc !== 32'(4 * (k + 1)) || out_pc !== 32'(4 * k) || out_instr !== instr_mem[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_word%0d: pc=%h opc=%h instr=%h v=%b required pc=%h opc=%h instr=%h v=1",
                         k, pc, out_pc, out_instr, out_valid, 4 * (k + 1), 4 * k, instr_mem[k]);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pc !== 32'hC || out_pc !== 32'h8 || out_instr !== instr_mem[2] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h opc=%h instr=%h v=%b required pc=c opc=8 instr=%h v=1",
                         k, pc, out_pc, out_instr, out_valid, instr_mem[2]);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_pc !== 32'hC || out_instr !== instr_mem[3] || pc !== 32'h10) begin
            errors++;
            $display("FAIL stall_release: opc=%h instr=%h pc=%h required opc=c instr=%h pc=10", out_pc, out_instr, pc, instr_mem[3]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (out_pc !== 32'h4) begin
            errors++;
            $display("FAIL redirect_setup: opc=%h required 4", out_pc);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pc !== 32'h40) begin
            errors++;
            $display("FAIL redirect_flush: v=%b pc=%h required v=0 pc=40", out_valid, pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== instr_mem[16]) begin
            errors++;
            $display("FAIL redirect_first: v=%b opc=%h instr=%h required v=1 opc=40 instr=%h", out_valid, out_pc, out_instr, instr_mem[16]);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] held_pc;
        held_pc = pc;
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || pc !== held_pc) begin
            errors++;
            $display("FAIL misalign_enter: fault=%b v=%b pc=%h required fault=1 v=0 pc=%h", fault, out_valid, pc, held_pc);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (fault !== 1'b1 || out_valid !== 1'b0 || pc !== held_pc) begin
                errors++;
                $display("FAIL misalign_hold%0d: fault=%b v=%b pc=%h required fault=1 v=0 pc=%h", k, fault, out_valid, pc, held_pc);
            end
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || pc !== held_pc) begin
            errors++;
            $display("FAIL fault_ignores_redirect: fault=%b v=%b pc=%h required fault=1 v=0 pc=%h", fault, out_valid, pc, held_pc);
        end
    endtask

    task automatic test_range();
        int n;
        do_reset();
        out_ready = 1'b1;
        n = 0;
        while (fault !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        // 1 idle edge, 64 captures reaching pc=0x100, then the faulting edge
        checks++;
        if (n !== 66 || fault !== 1'b1 || out_pc !== 32'hFC || out_valid !== 1'b0 || pc !== 32'h100) begin
            errors++;
            $display("FAIL range_fault: edges=%0d fault=%b opc=%h v=%b pc=%h required edges=66 fault=1 opc=fc v=0 pc=100",
                     n, fault, out_pc, out_valid, pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        out_ready = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: pc=%h v=%b instr=%h opc=%h fault=%b required all zero", pc, out_valid, out_instr, out_pc, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_next, tgt, op, oi;
        logic        rdy, rv, v, stall;
        int          accepts;
        do_reset();
        tick();
        exp_next = 32'h0;
        accepts = 0;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0) || (exp_next >= 32'hC0);
            tgt = 32'($urandom_range(0, 31)) * 32'd4;
            out_ready = rdy;
            redirect_valid = rv;
            redirect_target = tgt;
            v  = out_valid;
            op = out_pc;
            oi = out_instr;
            if (v && rdy) begin
                checks++;
                if (op !== exp_next || oi !== instr_mem[op[7:2]]) begin
                    errors++;
                    $display("FAIL rand_accept%0d: opc=%h instr=%h required opc=%h instr=%h", i, op, oi, exp_next, instr_mem[exp_next[7:2]]);
                end
                exp_next = op + 32'd4;
                accepts++;
            end
            if (rv) exp_next = tgt;
            stall = v && !rdy && !rv;
            tick();
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL rand_fault%0d: fault=%b required 0", i, fault);
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== op || out_instr !== oi) begin
                    errors++;
                    $display("FAIL rand_stall%0d: v=%b opc=%h instr=%h required v=1 opc=%h instr=%h", i, out_valid, out_pc, out_instr, op, oi);
                end
            end
            if (rv) begin
                checks++;
                if (out_valid !== 1'b0 || pc !== tgt) begin
                    errors++;
                    $display("FAIL rand_redirect%0d: v=%b pc=%h required v=0 pc=%h", i, out_valid, pc, tgt);
                end
            end
        end
        redirect_valid = 1'b0;
        checks++;
        if (accepts < 100) begin
            errors++;
            $display("FAIL rand_throughput: accepts=%0d required >=100", accepts);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) instr_mem[i] = $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The block SHALL provide parameter MEM_WORDS, default 64, as the instruction memory depth in 32-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pc, output, 32 bits: byte fetch address driven to instrMem.
REQ-006 The block SHALL have port instr, input, 32 bits: instruction returned combinationally by instrMem for pc in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch or jump request.
REQ-008 The block SHALL have port redirect_target, input, 32 bits: byte address for the redirect.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_instr and out_pc hold a fetched instruction.
REQ-010 The block SHALL have port out_ready, input, 1 bit: decode accepts the output this cycle.
REQ-011 The block SHALL have port out_instr, output, 32 bits: fetched instruction.
REQ-012 The block SHALL have port out_pc, output, 32 bits: address of out_instr.
REQ-013 The block SHALL have port fault, output, 1 bit: sticky fetch fault.

Function
REQ-014 FSM states SHALL be IDLE, FETCH and FAULT.
REQ-015 IDLE: entered on reset; SHALL go to FETCH after 1 clock; no capture in IDLE.
REQ-016 FETCH, advance condition SHALL be (!out_valid || out_ready) && !redirect_valid.
REQ-017 On advance: out_instr<=instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-018 Latency SHALL be 1 cycle: the word at address A appears on out_instr on the edge after pc==A.
REQ-019 Stall: with out_valid=1 and out_ready=0, pc, out_instr, out_pc and out_valid SHALL hold unchanged.
REQ-020 out_valid SHALL fall to 0 after an accept when no new capture occurs in the same cycle.
REQ-021 Redirect takes priority over advance and stall: pc<=redirect_target and out_valid<=0, flushing any held instruction.
REQ-022 The first instruction after a redirect SHALL appear 1 cycle after the redirect edge.
REQ-023 Redirect with redirect_target[1:0]!=0 SHALL go to FAULT instead.
REQ-024 In FETCH, pc >= MEM_WORDS*4 SHALL go to FAULT with no capture.
REQ-025 FAULT: fault=1, out_valid=0, pc holds; the state SHALL exit only by reset, and redirects are ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); with default parameters the range fault (REQ-024) fires first.
REQ-027 Simultaneous redirect and out_ready=1 with out_valid=1 SHALL count the old instruction as accepted and then flush it.
REQ-028 pc SHALL always be word-aligned outside FAULT.

Reset
REQ-029 While rst_n=0, asynchronously: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, state=IDLE.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.
REQ-031 A misaligned RESET_PC SHALL cause FAULT on the first FETCH cycle.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, INSTR_W=32, PC_STEP=4 and NOP=32'h0000_0000.
REQ-033 Sub-module pc_gen SHALL compute the next pc (hold, +4 or redirect) and the alignment/range fault.
REQ-034 instrMem SHALL be instantiated beside instr_fetch in the bench or top level, not inside it.

Verification
REQ-035 Bench SHALL instantiate instr_fetch plus instrMem loaded from test.txt, and SHALL check each scenario below.
REQ-036 Reset release, out_ready=1 -> pc 0,4,8 on cycles 1,2,3 after IDLE; out_pc 0,4,8 one cycle later; out_instr = allInstr[0],[1],[2].
REQ-037 out_ready=0 for 3 cycles while out_pc=8 -> pc stays 12, out_instr stays allInstr[2]; on release, out_pc=12 on the next edge.
REQ-038 redirect_valid with target 32'h40 while out_pc=4 -> next cycle out_valid=0 and pc=0x40; following cycle out_instr=allInstr[16], out_pc=0x40.
REQ-039 redirect_target 32'h42 -> fault=1, out_valid=0 on the next edge and held for 10 cycles; a further redirect to 0 is ignored.
REQ-040 Sequential fetch reaching pc=0x100 with MEM_WORDS=64 -> fault=1, last out_pc=0xFC; rst_n pulse mid-stall -> all outputs 0 immediately.
